// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating direction counters,
// execute-stage mispredict detection and redirect PC. Optional statistics under BP_STATS_EN.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic        ActualTakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int         ENTRIES = 2 ** IDX_W;
  localparam logic [1:0] CTR_SN  = 2'b00;
  localparam logic [1:0] CTR_WN  = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]   tag_reg    [ENTRIES];
  logic [31:0]        target_reg [ENTRIES];
  logic [1:0]         ctr_reg    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] f_tag;
  logic [TAG_W-1:0] e_tag;
  logic             f_hit;
  logic             e_hit;
  logic [1:0]       ctr_next;
  logic             upd_ctr;
  logic             alloc;
  logic             wr_target;

  // Fetch lookup is purely combinational so the prediction is available in the same cycle.
  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[31:IDX_W+2];
  assign f_hit = valid_reg[f_idx] && (tag_reg[f_idx] == f_tag);

  assign PredTakenF  = f_hit && ctr_reg[f_idx][1];
  assign PredTargetF = f_hit ? target_reg[f_idx] : PCF + 32'd4;

  assign MispredictE = BranchE && ((ActualTakenE != PredTakenE) ||
                       (ActualTakenE && PredTakenE && (PredTargetE != BranchTargetE)));
  assign CorrectPCE  = ActualTakenE ? BranchTargetE : PCE + 32'd4;

  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[31:IDX_W+2];
  assign e_hit = valid_reg[e_idx] && (tag_reg[e_idx] == e_tag);

  assign upd_ctr   = BranchE && e_hit;
  assign alloc     = BranchE && !e_hit && ActualTakenE;
  assign wr_target = BranchE && ActualTakenE;

  always_comb begin
    ctr_next = ctr_reg[e_idx];
    if (ActualTakenE) begin
      if (ctr_reg[e_idx] != CTR_ST) ctr_next = ctr_reg[e_idx] + 2'd1;
    end else begin
      if (ctr_reg[e_idx] != CTR_SN) ctr_next = ctr_reg[e_idx] - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= CTR_WN;
    end else if (upd_ctr) begin
      ctr_reg[e_idx] <= ctr_next;
    end else if (alloc) begin
      valid_reg[e_idx] <= 1'b1;
      ctr_reg[e_idx]   <= CTR_WT;
    end
  end

  // Tag/target need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge CLK) begin
    if (wr_target) begin
      tag_reg[e_idx]    <= e_tag;
      target_reg[e_idx] <= BranchTargetE;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_count_reg;
  logic [31:0] miss_count_reg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      br_count_reg   <= '0;
      miss_count_reg <= '0;
    end else begin
      if (BranchE && (br_count_reg != 32'hFFFF_FFFF))
        br_count_reg <= br_count_reg + 32'd1;
      if (MispredictE && (miss_count_reg != 32'hFFFF_FFFF))
        miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  assign BrCount   = br_count_reg;
  assign MissCount = miss_count_reg;
`else
  assign BrCount   = 32'h0;
  assign MissCount = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, mid-stream reset
// sequence, then randomized traffic against a simple array-based model of the predictor.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE;
  logic        ActualTakenE;
  logic [31:0] PCE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] CorrectPCE;
  logic [31:0] BrCount;
  logic [31:0] MissCount;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  branch_predictor dut (
    .CLK(CLK), .Reset(Reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BranchE(BranchE), .ActualTakenE(ActualTakenE), .PCE(PCE), .BranchTargetE(BranchTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .CorrectPCE(CorrectPCE), .BrCount(BrCount), .MissCount(MissCount)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_mis = 0;
  int unsigned exp_br = 0;
  int unsigned exp_miss = 0;

  // Reference model: 16 direct-mapped entries, counter held as an integer 0..3.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
    int idx = int'((pc / 4) % 16);
    bit hit = m_valid[idx] && (m_tag[idx] == pc / 64);
    pt  = hit && (m_ctr[idx] >= 2);
    tgt = hit ? m_target[idx] : pc + 32'd4;
  endfunction

  function automatic void model_update(input logic br, input logic tk, input logic [31:0] pce,
                                       input logic [31:0] btgt);
    int idx = int'((pce / 4) % 16);
    bit hit = m_valid[idx] && (m_tag[idx] == pce / 64);
    if (!br) return;
    if (hit) begin
      if (tk) begin
        m_ctr[idx]    = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
        m_target[idx] = btgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (tk) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = pce / 64;
      m_target[idx] = btgt;
      m_ctr[idx]    = 2;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] pcf, input logic br, input logic tk,
                     input logic [31:0] pce, input logic [31:0] btgt, input logic pte,
                     input logic [31:0] ptgte, input logic rst, input logic e_pt,
                     input logic [31:0] e_ptgt, input logic e_mis, input logic [31:0] e_cpc);
    Reset = rst; PCF = pcf; BranchE = br; ActualTakenE = tk; PCE = pce;
    BranchTargetE = btgt; PredTakenE = pte; PredTargetE = ptgte;
    @(negedge CLK);
    chk({nm, ".PredTakenF"},  {31'd0, PredTakenF}, {31'd0, e_pt});
    chk({nm, ".PredTargetF"}, PredTargetF, e_ptgt);
    chk({nm, ".MispredictE"}, {31'd0, MispredictE}, {31'd0, e_mis});
    chk({nm, ".CorrectPCE"},  CorrectPCE, e_cpc);
    chk({nm, ".BrCount"},     BrCount, STATS ? exp_br : 32'd0);
    chk({nm, ".MissCount"},   MissCount, STATS ? exp_miss : 32'd0);
    $display("%s pcf=%h pt=%0d ptgt=%h br=%0d mis=%0d cpc=%h brc=%0d missc=%0d",
             nm, pcf, PredTakenF, PredTargetF, br, MispredictE, CorrectPCE, BrCount, MissCount);
    if (rst) begin
      exp_br = 0; exp_miss = 0;
      model_reset();
    end else begin
      if (br) exp_br++;
      if (e_mis) exp_miss++;
      model_update(br, tk, pce, btgt);
    end
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [31:0] pcf;
    logic        br;
    logic        tk;
    logic [31:0] pce;
    logic [31:0] btgt;
    logic        pte;
    logic [31:0] ptgte;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_cpc;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic        pt, mpt, tk, br, pte, rst, emis;
    logic [31:0] ptgt, mtgt, pcf, pce, btgt, ptgte, ecpc;

    //          pcf          br tk pce          btgt   pte ptgtE     | pt ptgt         mis cpc
    tbl[0]  = '{32'h100,     0, 0, 32'h100,     32'h0,   0, 32'h0,     0, 32'h104,     0, 32'h104};
    tbl[1]  = '{32'h100,     1, 1, 32'h100,     32'h200, 0, 32'h104,   0, 32'h104,     1, 32'h200};
    tbl[2]  = '{32'h100,     0, 0, 32'h100,     32'h0,   0, 32'h0,     1, 32'h200,     0, 32'h104};
    tbl[3]  = '{32'h100,     1, 0, 32'h100,     32'h200, 1, 32'h200,   1, 32'h200,     1, 32'h104};
    tbl[4]  = '{32'h100,     1, 0, 32'h100,     32'h200, 0, 32'h200,   0, 32'h200,     0, 32'h104};
    tbl[5]  = '{32'h100,     1, 0, 32'h100,     32'h200, 0, 32'h200,   0, 32'h200,     0, 32'h104};
    tbl[6]  = '{32'h100,     1, 0, 32'h100,     32'h200, 0, 32'h200,   0, 32'h200,     0, 32'h104};
    tbl[7]  = '{32'h100,     1, 1, 32'h100,     32'h200, 0, 32'h200,   0, 32'h200,     1, 32'h200};
    tbl[8]  = '{32'h100,     1, 1, 32'h100,     32'h200, 0, 32'h200,   0, 32'h200,     1, 32'h200};
    tbl[9]  = '{32'h100,     0, 0, 32'h100,     32'h0,   0, 32'h0,     1, 32'h200,     0, 32'h104};
    tbl[10] = '{32'h140,     1, 1, 32'h140,     32'h500, 0, 32'h144,   0, 32'h144,     1, 32'h500};
    tbl[11] = '{32'h100,     0, 0, 32'h100,     32'h0,   0, 32'h0,     0, 32'h104,     0, 32'h104};
    tbl[12] = '{32'h140,     0, 0, 32'h100,     32'h0,   0, 32'h0,     1, 32'h500,     0, 32'h104};
    tbl[13] = '{32'h108,     1, 1, 32'h108,     32'h200, 0, 32'h10C,   0, 32'h10C,     1, 32'h200};
    tbl[14] = '{32'h108,     0, 0, 32'h100,     32'h0,   0, 32'h0,     1, 32'h200,     0, 32'h104};
    tbl[15] = '{32'h108,     1, 1, 32'h108,     32'h300, 1, 32'h200,   1, 32'h200,     1, 32'h300};
    tbl[16] = '{32'h108,     0, 0, 32'h100,     32'h0,   0, 32'h0,     1, 32'h300,     0, 32'h104};
    tbl[17] = '{32'h108,     1, 1, 32'h108,     32'h300, 1, 32'h300,   1, 32'h300,     0, 32'h300};
    tbl[18] = '{32'h10C,     1, 0, 32'h10C,     32'h0,   0, 32'h110,   0, 32'h110,     0, 32'h110};
    tbl[19] = '{32'h10C,     0, 0, 32'h100,     32'h0,   0, 32'h0,     0, 32'h110,     0, 32'h104};
    tbl[20] = '{32'hFFFFFFFC,1, 0, 32'hFFFFFFFC,32'h0,   0, 32'h0,     0, 32'h0,       0, 32'h0};
    tbl[21] = '{32'h100,     0, 1, 32'h100,     32'h700, 0, 32'h0,     0, 32'h104,     0, 32'h700};

    Reset = 1'b1; PCF = '0; BranchE = 1'b0; ActualTakenE = 1'b0; PCE = '0;
    BranchTargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run($sformatf("vec%0d", i), tbl[i].pcf, tbl[i].br, tbl[i].tk, tbl[i].pce, tbl[i].btgt,
          tbl[i].pte, tbl[i].ptgte, 1'b0, tbl[i].e_pt, tbl[i].e_ptgt, tbl[i].e_mis, tbl[i].e_cpc);
    end

    // Reset mid-stream while a taken branch resolves: reset wins, table and counters clear.
    run("rst_mid", 32'h108, 1, 1, 32'h108, 32'h900, 1, 32'h300, 1'b1, 1, 32'h300, 1, 32'h900);
    run("post_rst_a", 32'h108, 0, 0, 32'h100, 32'h0, 0, 32'h0, 1'b0, 0, 32'h10C, 0, 32'h104);
    run("post_rst_b", 32'h140, 0, 0, 32'h100, 32'h0, 0, 32'h0, 1'b0, 0, 32'h144, 0, 32'h104);

    for (int i = 0; i < 400; i++) begin
      pcf  = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
      pce  = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
      btgt = 32'($urandom_range(1, 4)) << 8;
      br   = ($urandom_range(0, 9) < 7);
      tk   = $urandom_range(0, 1) == 1;
      rst  = ($urandom_range(0, 63) == 0);
      model_lookup(pce, mpt, mtgt);
      if ($urandom_range(0, 3) != 0) begin
        pte = mpt; ptgte = mtgt;
      end else begin
        pte = $urandom_range(0, 1) == 1; ptgte = 32'($urandom_range(1, 4)) << 8;
      end
      model_lookup(pcf, pt, ptgt);
      emis = br && ((tk != pte) || (tk && pte && (ptgte != btgt)));
      ecpc = tk ? btgt : pce + 32'd4;
      run($sformatf("rnd%0d", i), pcf, br, tk, pce, btgt, pte, ptgte, rst, pt, ptgt, emis, ecpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
